// File: rtl/ty_stream_pkg.sv
// Shared stream geometry for the kernel pack/unpack stages: lane count, lane width
// and the lane-data type, plus a lane extraction helper.
package ty_stream_pkg;

    localparam int NLANES = 4;
    localparam int LANEW  = 64;

    typedef logic [LANEW-1:0] lane_t;

    function automatic lane_t lane_get(input logic [NLANES*LANEW-1:0] word, input int idx);
        lane_get = word[idx*LANEW +: LANEW];
    endfunction

endpackage

// File: rtl/func_out_unpack.sv
// Splits one packed kernel output word into NLANES independent AXI-stream lanes.
// A single holding register is drained lane by lane; the next word loads on the final drain.
module func_out_unpack
    import ty_stream_pkg::*;
#(
    parameter int NLANES = ty_stream_pkg::NLANES,
    parameter int LANEW  = ty_stream_pkg::LANEW
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_tvalid,
    input  logic [NLANES*LANEW-1:0] s_tdata,
    output logic                    s_tready,
    output logic [NLANES-1:0]       m_tvalid,
    output logic [NLANES*LANEW-1:0] m_tdata,
    input  logic [NLANES-1:0]       m_tready,
    output logic [31:0]             word_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]              r_state;
    logic [NLANES-1:0]       r_pending;
    logic [NLANES*LANEW-1:0] r_hold;
    logic [31:0]             r_word_count;

    logic [0:0]              w_state_nxt;
    logic [NLANES-1:0]       w_pending_nxt;
    logic [NLANES-1:0]       w_valid;
    logic [NLANES-1:0]       w_fire;
    logic                    w_full;
    logic                    w_last_drain;
    logic                    w_ready;
    logic                    w_load;

    // Handshake decode: which lanes complete now and whether this empties the word.
    always_comb begin
        w_full       = (r_state == ST_HOLD);
        w_valid      = {NLANES{w_full}} & r_pending;
        w_fire       = w_valid & m_tready;
        w_last_drain = w_full && ((r_pending & ~w_fire) == {NLANES{1'b0}});
        w_ready      = !w_full || w_last_drain;
        w_load       = s_tvalid && w_ready;
    end

    // Next state and pending mask; a drained word is replaced in the same edge when input waits.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_EMPTY: begin
                if (w_load) begin
                    w_state_nxt   = ST_HOLD;
                    w_pending_nxt = {NLANES{1'b1}};
                end else begin
                    w_state_nxt   = ST_EMPTY;
                    w_pending_nxt = {NLANES{1'b0}};
                end
            end
            ST_HOLD: begin
                if (w_last_drain && s_tvalid) begin
                    w_state_nxt   = ST_HOLD;
                    w_pending_nxt = {NLANES{1'b1}};
                end else if (w_last_drain) begin
                    w_state_nxt   = ST_EMPTY;
                    w_pending_nxt = {NLANES{1'b0}};
                end else begin
                    w_state_nxt   = ST_HOLD;
                    w_pending_nxt = r_pending & ~w_fire;
                end
            end
            default: begin
                w_state_nxt   = ST_EMPTY;
                w_pending_nxt = {NLANES{1'b0}};
            end
        endcase
    end

    // State, pending mask and delivered-word counter.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_state      <= ST_EMPTY;
            r_pending    <= {NLANES{1'b0}};
            r_word_count <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_last_drain) begin
                r_word_count <= r_word_count + 32'd1;
            end else begin
                r_word_count <= r_word_count;
            end
        end
    end

    // Holding register only written on an accepted input word.
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_hold <= {(NLANES*LANEW){1'b0}};
        end else if (w_load) begin
            r_hold <= s_tdata;
        end else begin
            r_hold <= r_hold;
        end
    end

    // s_tready must stay combinational so a draining word can be replaced without a bubble.
    always_comb begin
        s_tready   = w_ready;
        m_tvalid   = w_valid;
        m_tdata    = r_hold;
        word_count = r_word_count;
    end

endmodule

// File: tb/tb_func_out_unpack.sv
// Directed and random bench for func_out_unpack with a per-lane queue scoreboard.
module tb_func_out_unpack;
    import ty_stream_pkg::*;

    localparam int NL = NLANES;
    localparam int LW = LANEW;
    localparam int WW = NL * LW;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_tvalid;
    logic [WW-1:0] s_tdata;
    logic          s_tready;
    logic [NL-1:0] m_tvalid;
    logic [WW-1:0] m_tdata;
    logic [NL-1:0] m_tready;
    logic [31:0]   word_count;

    int          errors = 0;
    int          checks = 0;
    lane_t       q[NL][$];
    int          rem[$];
    int unsigned exp_count;

    func_out_unpack #(.NLANES(NL), .LANEW(LW)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tready   (m_tready),
        .word_count (word_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) q[i].delete();
        rem.delete();
        exp_count = 32'd0;
    endtask

    function automatic logic [WW-1:0] mkword(input int k);
        logic [WW-1:0] w;
        for (int i = 0; i < NL; i++) w[i*LW +: LW] = {32'(k), 32'(i)};
        return w;
    endfunction

    function automatic logic [WW-1:0] rndword();
        logic [WW-1:0] w;
        for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // One clock cycle: drive, compare against the scoreboard, advance the scoreboard.
    task automatic cycle(input logic sv, input logic [WW-1:0] sd, input logic [NL-1:0] mr);
        logic          exp_ready;
        logic [NL-1:0] exp_valid;
        s_tvalid = sv;
        s_tdata  = sd;
        m_tready = mr;
        #1;
        exp_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            exp_valid[i] = (q[i].size() != 0);
            if (exp_valid[i] && !mr[i]) exp_ready = 1'b0;
        end
        check("m_tvalid", WW'(m_tvalid), WW'(exp_valid));
        check("s_tready", WW'(s_tready), WW'(exp_ready));
        check("word_count", WW'(word_count), WW'(exp_count));
        for (int i = 0; i < NL; i++)
            if (exp_valid[i]) check($sformatf("lane%0d_data", i), WW'(lane_get(m_tdata, i)), WW'(q[i][0]));
        for (int i = 0; i < NL; i++) begin
            if (exp_valid[i] && mr[i]) begin
                void'(q[i].pop_front());
                rem[0] = rem[0] - 1;
            end
        end
        if (rem.size() != 0 && rem[0] == 0) begin
            void'(rem.pop_front());
            exp_count++;
        end
        if (sv && exp_ready) begin
            for (int i = 0; i < NL; i++) q[i].push_back(lane_get(sd, i));
            rem.push_back(NL);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = '0;
        model_clear();
        @(posedge aclk);
        #1;
        check("rst_s_tready", WW'(s_tready), WW'(1'b1));
        check("rst_m_tvalid", WW'(m_tvalid), '0);
        check("rst_m_tdata", m_tdata, '0);
        check("rst_word_count", WW'(word_count), '0);
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = '0;
        exp_count = 32'd0;

        // Back-to-back words, all sinks ready.
        do_reset();
        for (int k = 1; k <= 8; k++) cycle(1'b1, mkword(k), 4'hF);
        cycle(1'b0, '0, 4'hF);
        cycle(1'b0, '0, 4'hF);
        check("t034_count", WW'(word_count), WW'(32'd8));

        // Lanes 0,2 ready first, 1,3 later.
        do_reset();
        cycle(1'b1, {64'd3, 64'd2, 64'd1, 64'd0}, 4'b0101);
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, 4'b0101);
        check("t035_not_ready", WW'(s_tready), WW'(1'b0));
        cycle(1'b0, '0, 4'hF);
        cycle(1'b0, '0, 4'hF);
        check("t035_count", WW'(word_count), WW'(32'd1));

        // Lane 3 stalled with the next word waiting on the input.
        do_reset();
        cycle(1'b1, mkword(16'hA0), 4'hF);
        for (int c = 0; c < 10; c++) cycle(1'b1, mkword(16'hB0), 4'b0111);
        check("t036_lane3_stable", WW'(lane_get(m_tdata, 3)), WW'({32'h0000_00A0, 32'd3}));
        cycle(1'b1, mkword(16'hB0), 4'hF);
        cycle(1'b0, '0, 4'hF);
        cycle(1'b0, '0, 4'hF);
        check("t036_count", WW'(word_count), WW'(32'd2));

        // Asynchronous reset with lanes 1,3 still pending.
        do_reset();
        cycle(1'b1, mkword(16'hC0), 4'b0101);
        cycle(1'b0, '0, 4'b0101);
        s_tvalid = 1'b0;
        m_tready = 4'b0000;
        #1;
        check("t037_pending", WW'(m_tvalid), WW'(4'b1010));
        areset = 1'b0;
        #1;
        check("t037_async_valid", WW'(m_tvalid), '0);
        check("t037_async_ready", WW'(s_tready), WW'(1'b1));
        model_clear();
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        for (int c = 0; c < 4; c++) cycle(1'b0, '0, 4'hF);
        check("t037_count", WW'(word_count), '0);

        // Counter wrap.
        do_reset();
        force dut.r_word_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_word_count;
        exp_count = 32'hFFFF_FFFF;
        check("t038_preload", WW'(word_count), WW'(32'hFFFF_FFFF));
        cycle(1'b1, mkword(16'hD0), 4'hF);
        cycle(1'b0, '0, 4'hF);
        cycle(1'b0, '0, 4'hF);
        check("t038_wrap", WW'(word_count), '0);

        // Random traffic against the scoreboard.
        do_reset();
        for (int c = 0; c < 10000; c++)
            cycle(1'($urandom_range(0, 1)), rndword(), 4'($urandom_range(0, 15)));
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, 4'hF);
        check("t039_drained", WW'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), '0);
        check("t039_idle_valid", WW'(m_tvalid), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
